// File: rtl/sudoku_puzzle_feeder.sv
// Row-stream to puzzle assembler with a small FIFO of complete puzzles for sudoku_core.
// Rows are sanitised (A..F -> 0), framed on row_last, and committed on row 8.
module sudoku_puzzle_feeder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              row_valid,
  input  logic [35:0]       row_data,
  input  logic              row_last,
  output logic              row_ready,
  input  logic              ans_space,
  output logic              puzzle_avail,
  output logic [323:0]      puzzle_data,
  input  logic              read_puzzle,
  output logic [2:0]        fill_cnt,
  output logic              frame_err,
  output logic              cell_err,
  output logic [CNT_W-1:0]  puzzles_loaded
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRIES = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);

  logic [3:0]       row_cnt;
  logic [323:0]     asm_q;
  logic [323:0]     pz_buf [ENTRIES];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  logic [35:0] clean_row;
  logic        bad_cell;
  logic        last_exp, frame_ok, accept, commit, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    clean_row = row_data;
    bad_cell  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (row_data[4*i +: 4] > 4'd9) begin
        clean_row[4*i +: 4] = 4'd0;
        bad_cell            = 1'b1;
      end
    end
  end

  // Stall depends only on registered state, so a same-cycle pop cannot release it.
  assign row_ready    = !(row_cnt == 4'd8 && fill_cnt == FULL);
  assign last_exp     = (row_cnt == 4'd8);
  assign frame_ok     = (row_last == last_exp);
  assign accept       = row_valid && row_ready;
  assign commit       = accept && frame_ok && last_exp;
  assign pop          = read_puzzle && (fill_cnt != 3'd0);
  assign puzzle_avail = (fill_cnt != 3'd0) && ans_space;
  assign puzzle_data  = (fill_cnt != 3'd0) ? pz_buf[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt        <= '0;
      asm_q          <= '0;
      for (int i = 0; i < ENTRIES; i++) pz_buf[i] <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      frame_err      <= 1'b0;
      cell_err       <= 1'b0;
      puzzles_loaded <= '0;
    end else begin
      frame_err <= accept && !frame_ok;
      cell_err  <= accept && bad_cell;

      if (accept) begin
        if (!frame_ok || last_exp) begin
          row_cnt <= '0;
          asm_q   <= '0;
        end else begin
          asm_q[(8 - int'(row_cnt))*36 +: 36] <= clean_row;
          row_cnt <= row_cnt + 4'd1;
        end
      end

      if (pop) begin
        pz_buf[rd_ptr] <= '0;
        rd_ptr         <= ptr_inc(rd_ptr);
      end

      // wr_ptr never equals rd_ptr when commit and pop coincide (fill is neither 0 nor full).
      if (commit) begin
        pz_buf[wr_ptr] <= {asm_q[323:36], clean_row};
        wr_ptr         <= ptr_inc(wr_ptr);
        puzzles_loaded <= puzzles_loaded + 1'b1;
      end

      case ({commit, pop})
        2'b10:   fill_cnt <= fill_cnt + 3'd1;
        2'b01:   fill_cnt <= fill_cnt - 3'd1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_puzzle_feeder.sv
// Directed, table-driven bench for sudoku_puzzle_feeder (DEPTH=2).
module tb_sudoku_puzzle_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         row_valid, row_last, ans_space, read_puzzle;
  logic [35:0]  row_data;
  logic         row_ready, puzzle_avail, frame_err, cell_err;
  logic [323:0] puzzle_data;
  logic [2:0]   fill_cnt;
  logic [15:0]  puzzles_loaded;

  int checks = 0;
  int errors = 0;

  sudoku_puzzle_feeder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_data(row_data), .row_last(row_last), .row_ready(row_ready),
    .ans_space(ans_space), .puzzle_avail(puzzle_avail), .puzzle_data(puzzle_data),
    .read_puzzle(read_puzzle), .fill_cnt(fill_cnt), .frame_err(frame_err),
    .cell_err(cell_err), .puzzles_loaded(puzzles_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [35:0] rd;
    logic        rl;
    logic        rp;
    logic        as;
    logic        e_ready;
    logic        e_avail;
    logic [2:0]  e_fill;
    logic        e_ferr;
    logic        e_cerr;
    logic [15:0] e_loaded;
    logic [35:0] e_top;
    logic [35:0] e_bot;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [35:0] rowv(input int k);
    logic [3:0] n;
    n = 4'(k);
    return {9{n}};
  endfunction

  task automatic add(input logic rv, input logic [35:0] rd, input logic rl, input logic rp,
                     input logic as, input logic er, input logic ea, input logic [2:0] ef,
                     input logic [15:0] el, input logic [35:0] et, input logic [35:0] eb);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rl = rl; v.rp = rp; v.as = as;
    v.e_ready = er; v.e_avail = ea; v.e_fill = ef; v.e_ferr = 1'b0; v.e_cerr = 1'b0;
    v.e_loaded = el; v.e_top = et; v.e_bot = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [323:0] act, input logic [323:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [35:0] rd, input logic rl, input logic rp);
    row_valid = rv; row_data = rd; row_last = rl; read_puzzle = rp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [35:0] rd, input logic rl);
    drive(1'b1, rd, rl, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // P1 row r = r+1, P2 row r = 8-r, P3 row r = r.
    for (int r = 0; r < 9; r++)
      add(1, rowv(r+1), r == 8, 0, 1, 1, r == 8, (r == 8) ? 3'd1 : 3'd0,
          (r == 8) ? 16'd1 : 16'd0, (r == 8) ? rowv(1) : '0, (r == 8) ? rowv(9) : '0);
    for (int r = 0; r < 9; r++)
      add(1, rowv(8-r), r == 8, 0, 1, 1, 1, (r == 8) ? 3'd2 : 3'd1,
          (r == 8) ? 16'd2 : 16'd1, rowv(1), rowv(9));
    for (int r = 0; r < 8; r++)
      add(1, rowv(r), 0, 0, 1, r != 7, 1, 3'd2, 16'd2, rowv(1), rowv(9));
    add(1, rowv(8), 1, 0, 1, 0, 1, 3'd2, 16'd2, rowv(1), rowv(9));
    add(1, rowv(8), 1, 1, 1, 1, 1, 3'd1, 16'd2, rowv(8), rowv(0));
    add(1, rowv(8), 1, 0, 1, 1, 1, 3'd2, 16'd3, rowv(8), rowv(0));
    add(0, '0, 0, 1, 1, 1, 1, 3'd1, 16'd3, rowv(0), rowv(8));
    add(0, '0, 0, 1, 1, 1, 0, 3'd0, 16'd3, '0, '0);
    for (int i = 0; i < 6; i++)
      add(0, '0, 0, 1, 1, 1, 0, 3'd0, 16'd3, '0, '0);

    rst_n = 1'b0; ans_space = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_ready", row_ready, 1);
    chk("rst_avail", puzzle_avail, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_data", puzzle_data, '0);
    chk("rst_loaded", puzzles_loaded, 0);
    chk("rst_errs", {frame_err, cell_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].rd, tbl[i].rl, tbl[i].rp);
      ans_space = tbl[i].as;
      step();
      chk($sformatf("v%0d_ready", i), row_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_avail", i), puzzle_avail, tbl[i].e_avail);
      chk($sformatf("v%0d_fill", i), fill_cnt, tbl[i].e_fill);
      chk($sformatf("v%0d_errs", i), {frame_err, cell_err}, {tbl[i].e_ferr, tbl[i].e_cerr});
      chk($sformatf("v%0d_loaded", i), puzzles_loaded, tbl[i].e_loaded);
      chk($sformatf("v%0d_top", i), puzzle_data[323:288], tbl[i].e_top);
      chk($sformatf("v%0d_bot", i), puzzle_data[35:0], tbl[i].e_bot);
    end
    drive(1'b0, '0, 1'b0, 1'b0);

    // Early row_last on row 4.
    for (int r = 0; r < 4; r++) send(rowv(r+1), 1'b0);
    send(rowv(5), 1'b1);
    chk("frm_err_pulse", frame_err, 1);
    chk("frm_fill", fill_cnt, 0);
    chk("frm_loaded", puzzles_loaded, 3);
    step();
    chk("frm_err_clear", frame_err, 0);
    for (int r = 0; r < 9; r++) begin
      send(rowv(r+1), r == 8);
      if (r == 7) chk("frm_no_early_commit", fill_cnt, 0);
    end
    chk("frm_clean_err", frame_err, 0);
    chk("frm_clean_fill", fill_cnt, 1);
    chk("frm_clean_loaded", puzzles_loaded, 4);
    chk("frm_clean_top", puzzle_data[323:288], rowv(1));
    chk("frm_clean_bot", puzzle_data[35:0], rowv(9));
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("frm_pop_fill", fill_cnt, 0);

    // Illegal nibble 0xB at row 2, col 3.
    for (int r = 0; r < 9; r++) begin
      send((r == 2) ? 36'h333B33333 : rowv(r+1), r == 8);
      if (r == 2) chk("cell_err_pulse", cell_err, 1);
      if (r == 3) chk("cell_err_clear", cell_err, 0);
    end
    chk("cell_fill", fill_cnt, 1);
    chk("cell_loaded", puzzles_loaded, 5);
    chk("cell_row2", puzzle_data[251:216], 36'h333033333);
    chk("cell_row1", puzzle_data[287:252], rowv(2));
    chk("cell_row8", puzzle_data[35:0], rowv(9));

    ans_space = 1'b0;
    step();
    chk("nospace_avail", puzzle_avail, 0);
    chk("nospace_top", puzzle_data[323:288], rowv(1));
    ans_space = 1'b1;
    #1;
    chk("space_avail", puzzle_avail, 1);

    // Reset mid-frame with one puzzle buffered.
    for (int r = 0; r < 5; r++) send(rowv(r+1), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_fill", fill_cnt, 0);
    chk("mrst_avail", puzzle_avail, 0);
    chk("mrst_data", puzzle_data, '0);
    chk("mrst_loaded", puzzles_loaded, 0);
    chk("mrst_ready", row_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    step();
    for (int r = 0; r < 9; r++) send(rowv(8-r), r == 8);
    chk("mrst_frame_err", frame_err, 0);
    chk("mrst_commit_fill", fill_cnt, 1);
    chk("mrst_commit_loaded", puzzles_loaded, 1);
    chk("mrst_commit_top", puzzle_data[323:288], rowv(8));
    chk("mrst_commit_bot", puzzle_data[35:0], rowv(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sudoku_puzzle_feeder.md
Name: sudoku_puzzle_feeder

Overview:
- Upstream feeder for sudoku_core.
- Assembles puzzles from a row-wide stream of 9 cells x 4 bits, one row per beat, into full 324-bit puzzles.
- Buffers up to DEPTH complete puzzles and presents the head puzzle on puzzle_data / puzzle_avail to the core's puzzle_in / puzzle_avail.
- Pops the head on the core's read_puzzle.

Parameters:
- DEPTH, 2, number of complete-puzzle buffer entries. Legal values are 1..4.
- CNT_W, 16, width of the loaded-puzzle statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- row_valid  in  1  source has a row on row_data.
- row_data  in  36  one puzzle row. Bits [35:32] = col 0 … [3:0] = col 8.
- row_last  in  1  marks row 8 of a puzzle.
- row_ready  out  1  feeder accepts the row this cycle.
- ans_space  in  1  downstream answer store has a free slot.
- puzzle_avail  out  1  to sudoku_core puzzle_avail.
- puzzle_data  out  324  to sudoku_core puzzle_in. Row 0 col 0 at [323:320], row 8 col 8 at [3:0].
- read_puzzle  in  1  from sudoku_core read_puzzle.
- fill_cnt  out  3  number of complete puzzles buffered (0..DEPTH).
- frame_err  out  1  one-cycle pulse on a framing error.
- cell_err  out  1  one-cycle pulse when an accepted row holds a cell value A..F.
- puzzles_loaded  out  CNT_W  count of puzzles committed to the buffer, wraps.

Behaviour:
- Reset (rst_n low, async):
  - row_cnt=0, assembly register=0, all buffer entries=0, rd/wr pointers=0.
  - fill_cnt=0, puzzle_avail=0, puzzle_data=0, row_ready=1.
  - frame_err=0, cell_err=0, puzzles_loaded=0.
  - Reset mid-frame discards the partial puzzle and all buffered puzzles.
- Row accept: a beat is accepted at a rising edge when row_valid && row_ready.
- row_ready = !(row_cnt==8 && fill_cnt==DEPTH). Rows 0..7 are always accepted. Row 8 stalls while the buffer is full.
  - A pop in the same cycle does NOT release the stall. No combinational read_puzzle -> row_ready path.
- Cell sanitising: any nibble 0xA..0xF in an accepted row is written as 0 (unknown), and cell_err pulses the next cycle. The row is otherwise kept.
- Assembly: an accepted row is written to assembly slice [323-36*row_cnt -: 36].
  - row_cnt increments 0..8.
  - After row 8 is accepted, row_cnt wraps to 0.
- Framing:
  - Expected: row_last==1 exactly when row_cnt==8.
  - On mismatch, the offending beat is accepted but dropped.
  - The partial puzzle is discarded and row_cnt is set to 0.
  - frame_err pulses high for the following cycle.
  - Nothing is committed. puzzles_loaded is unchanged.
- Commit: on acceptance of a valid row 8, the completed puzzle (including row 8) is written to buffer[wr_ptr].
  - wr_ptr advances modulo DEPTH.
  - fill_cnt increments and puzzles_loaded increments (wraps at 2^CNT_W).
  - Latency: row 8 accepted at edge N; puzzle visible on puzzle_data (if the buffer was empty) and fill_cnt updated after edge N.
- Output:
  - puzzle_data = buffer[rd_ptr] when fill_cnt>0, else all-zero. It is a registered/storage value with no combinational path from row_data.
  - puzzle_avail = (fill_cnt!=0) && ans_space. This is combinational on ans_space only.
- Pop:
  - At an edge with read_puzzle && fill_cnt!=0, rd_ptr advances and fill_cnt decrements. The entry is zeroed.
  - read_puzzle with fill_cnt==0 is legal (core priming reads): it is ignored, with no error, and the core latches zeros.
  - read_puzzle while ans_space==0 but fill_cnt!=0 still pops. The core only issues a non-priming read when puzzle_avail is high.
- Simultaneous commit and pop: both take effect at the same edge. fill_cnt is unchanged, and both pointers advance.
  - With fill_cnt==DEPTH the commit cannot occur (row_ready=0).
  - With fill_cnt==0, the committed puzzle appears next cycle and the pop is ignored.
- fill_cnt never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then stream 9 rows of puzzle P1 (row r = 36'h{r+1 repeated 9 cells}), row_last on row 8, ans_space=1 → puzzle_avail rises the cycle after row 8 is accepted. puzzle_data[323:288]=36'h111111111, [35:0]=36'h999999999. fill_cnt=1, puzzles_loaded=1.
- DEPTH=2, load P1, P2, start P3 with no read_puzzle → rows 0..7 of P3 accepted, row_ready=0 at row 8, fill_cnt=2. Pulse read_puzzle once → next cycle puzzle_data=P2, row 8 of P3 accepted the following cycle, fill_cnt returns to 2.
- row_last asserted on row 4 → frame_err pulses 1 cycle, row_cnt=0, fill_cnt and puzzles_loaded unchanged. A subsequent clean 9-row frame commits correctly.
- Row containing cell 0xB at col 3 → cell_err pulses. The committed puzzle has 0 in that cell, and other cells are unchanged.
- fill_cnt=0, read_puzzle held 6 cycles (priming) → puzzle_data=0, fill_cnt stays 0, no error pulses. ans_space=0 with fill_cnt=1 → puzzle_avail=0, puzzle_data still shows the head.
- Assert rst_n low mid-frame (row_cnt=5) with fill_cnt=1 → all outputs return to reset values immediately. After release, the first accepted row is treated as row 0.
